// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: trigger-capture ring buffer with pre-trigger window and strobed per-sample readout
module adc_capture_buffer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH_LOG2 = 10,
  parameter int PRETRIG = 64
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [LANES*SAMPLE_WIDTH-1:0] DataIn,
  input  logic                          FastTrigger,
  input  logic                          Arm,
  input  logic                          AutoRearm,
  input  logic                          ReadEnable,
  output logic [SAMPLE_WIDTH-1:0]       DataOut,
  output logic                          DataReady,
  output logic                          Done,
  output logic [2:0]                    State
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int WW = LANES * SAMPLE_WIDTH;
  localparam logic [CW-1:0] PRE_N = CW'(PRETRIG);
  localparam logic [CW-1:0] POST_N = CW'(DEPTH - PRETRIG);
  localparam logic [CW-1:0] LAST_W = CW'(DEPTH - 1);
  localparam logic [LW-1:0] LAST_L = LW'(LANES - 1);
  localparam logic [DEPTH_LOG2-1:0] PRE_A = DEPTH_LOG2'(PRETRIG);
  typedef enum logic [2:0] {IDLE, ARMING, ARMED, POST, READOUT} state_t;
  state_t state;
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] rdata, word;
  logic [DEPTH_LOG2-1:0] wptr, raddr;
  logic [CW-1:0] fill, post, wcnt;
  logic [LW-1:0] lane;
  logic [1:0] phase;
  logic we;
  assign we = state == ARMING || state == ARMED || state == POST;
  assign State = state;
  always_ff @(posedge Clock) begin
    if (we) mem[wptr] <= DataIn;
    rdata <= mem[raddr];
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      wptr <= '0;
      raddr <= '0;
      fill <= '0;
      post <= '0;
      wcnt <= '0;
      lane <= '0;
      phase <= '0;
      word <= '0;
      DataOut <= '0;
      DataReady <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (we) wptr <= wptr + DEPTH_LOG2'(1);
      case (state)
        IDLE: if (Arm) begin
          state <= ARMING;
          fill <= '0;
        end
        ARMING: begin
          fill <= fill + CW'(1);
          if (fill + CW'(1) == PRE_N) state <= ARMED;
        end
        ARMED: if (FastTrigger) begin
          state <= POST_N == CW'(1) ? READOUT : POST;
          post <= CW'(1);
          raddr <= wptr - PRE_A;
          wcnt <= '0;
          phase <= '0;
        end
        POST: begin
          post <= post + CW'(1);
          if (post + CW'(1) == POST_N) state <= READOUT;
        end
        READOUT: begin
          if (phase == 2'd0) phase <= 2'd1;
          else if (phase == 2'd1) begin
            phase <= 2'd2;
            word <= rdata;
            DataOut <= rdata[SAMPLE_WIDTH-1:0];
            DataReady <= 1'b1;
            lane <= '0;
          end else if (ReadEnable) begin
            if (lane != LAST_L) begin
              lane <= lane + LW'(1);
              DataOut <= word[(int'(lane) + 1) * SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end else begin
              DataReady <= 1'b0;
              phase <= 2'd0;
              if (wcnt == LAST_W) begin
                Done <= 1'b1;
                state <= AutoRearm ? ARMING : IDLE;
                fill <= '0;
              end else begin
                raddr <= raddr + DEPTH_LOG2'(1);
                wcnt <= wcnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: self-checking bench for adc_capture_buffer with a cycle-level reference model
module tb_adc_capture_buffer;
  localparam int P = 4;
  localparam int D = 16;
  localparam int L = 4;
  localparam int NS = D * L;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data_in;
  logic trig = 1'b0, arm = 1'b0, auto_r = 1'b0, re = 1'b0;
  logic [7:0] dout;
  logic rdy, done;
  logic [2:0] st;
  int cyc = 0, lane_off = 0, checks = 0, passed = 0, done_cnt = 0;
  int first_ready = -1, entry = -1, tc = 0, d0 = 0, k = 0;
  int got[$];
  int ms = 0, arm_start = 0, tcyc = 0, n = 0, gap = 0;
  bit mdone = 0, mvalid = 0, rst_seen = 0, prev_rdy = 0, prev_re = 0, rdy_exp = 0;
  logic [7:0] prev_out = 8'd0;

  adc_capture_buffer #(.SAMPLE_WIDTH(8), .LANES(4), .DEPTH_LOG2(4), .PRETRIG(4)) dut (
    .Clock(clk), .Reset(rst), .DataIn(data_in), .FastTrigger(trig), .Arm(arm),
    .AutoRearm(auto_r), .ReadEnable(re), .DataOut(dout), .DataReady(rdy), .Done(done), .State(st)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [31:0] mk(int c, int lo);
    return {8'(c + 3 * lo), 8'(c + 2 * lo), 8'(c + lo), 8'(c)};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    data_in = mk(cyc, lane_off);
  endtask

  // Reference model: state timeline from cycle counts, record contents from the write-cycle arithmetic
  initial forever begin
    @(negedge clk);
    rdy_exp = ms == 4 && gap == 0;
    if (mvalid) begin
      chk("state", int'(st), ms);
      chk("ready", int'(rdy), int'(rdy_exp));
      chk("done", int'(done), int'(mdone));
      if (rdy_exp) chk("sample", int'(dout), (tcyc - P + n / L + (n % L) * lane_off) & 255);
      if (rst_seen) chk("data_after_reset", int'(dout), 0);
      if (prev_rdy && !prev_re && rdy) chk("hold", int'(dout), int'(prev_out));
    end
    if (done) done_cnt++;
    if (st == 3'd4 && entry < 0) entry = cyc;
    if (rdy && first_ready < 0) first_ready = cyc;
    if (rdy && re) got.push_back(int'(dout));
    prev_rdy = rdy;
    prev_re = re;
    prev_out = dout;
    rst_seen = rst;
    if (rst) begin
      mvalid = 1;
      ms = 0;
      mdone = 0;
      n = 0;
      gap = 0;
    end else if (mvalid) begin
      mdone = 0;
      case (ms)
        0: if (arm) begin ms = 1; arm_start = cyc + 1; end
        1: if (cyc == arm_start + P - 1) ms = 2;
        2: if (trig) begin ms = 3; tcyc = cyc; end
        3: if (cyc + 1 == tcyc + D - P) begin ms = 4; n = 0; gap = 2; end
        default: begin
          if (gap > 0) gap--;
          else if (re) begin
            n++;
            if (n == NS) begin
              mdone = 1;
              ms = auto_r ? 1 : 0;
              arm_start = cyc + 1;
            end else if (n % L == 0) gap = 2;
          end
        end
      endcase
    end
  end

  task automatic start_record();
    got.delete();
    first_ready = -1;
    entry = -1;
  endtask

  task automatic wait_state(int s, int lim);
    int i = 0;
    while (int'(st) != s && i < lim) begin tick(); i++; end
    chk("wait_state", int'(st), s);
  endtask

  task automatic fire(output int t);
    trig = 1'b1;
    t = cyc;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_done(int lim, bit rnd);
    int s0 = done_cnt;
    int i = 0;
    while (done_cnt == s0 && i < lim) begin
      if (rnd) re = 1'($urandom_range(0, 1));
      tick();
      i++;
    end
    re = 1'b1;
    chk("done_within_budget", done_cnt - s0, 1);
  endtask

  task automatic arm_and_fire(int wait_armed, output int t);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_state(2, 20);
    repeat (wait_armed) tick();
    fire(t);
  endtask

  task automatic check_record(int t);
    chk("n_samples", got.size(), NS);
    if (got.size() == NS) begin
      for (int g = 0; g < D; g++)
        chk("group_equal", int'(got[4*g] == got[4*g+1] && got[4*g] == got[4*g+2] && got[4*g] == got[4*g+3]), 1);
      chk("trigger_group", got[16], t & 255);
      chk("group_step", (got[60] - got[0]) & 255, 15);
    end
    chk("trig_to_readout", entry - t, 12);
    chk("first_ready_latency", first_ready - entry, 2);
  endtask

  initial begin
    data_in = mk(0, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", int'(st), 0);
    chk("rst_ready", int'(rdy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_data", int'(dout), 0);
    // basic capture
    re = 1'b1;
    start_record();
    arm_and_fire(10, tc);
    wait_done(300, 0);
    chk("idle_after_basic", int'(st), 0);
    check_record(tc);
    // early trigger during ARMING is ignored
    start_record();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    repeat (3) tick();
    trig = 1'b0;
    chk("early_still_arming", int'(st), 1);
    repeat (8) tick();
    chk("early_no_capture", int'(st), 2);
    fire(tc);
    wait_done(300, 0);
    check_record(tc);
    // ring wrap, with a stray Arm while ARMED
    start_record();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_state(2, 20);
    repeat (20) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (16) tick();
    fire(tc);
    wait_done(300, 0);
    check_record(tc);
    // backpressure
    start_record();
    arm_and_fire(5, tc);
    wait_done(1500, 1);
    check_record(tc);
    // auto rearm then a second record
    start_record();
    auto_r = 1'b1;
    arm_and_fire(3, tc);
    wait_done(300, 0);
    chk("rearm_state", int'(st), 1);
    check_record(tc);
    auto_r = 1'b0;
    start_record();
    wait_state(2, 20);
    fire(tc);
    wait_done(300, 0);
    chk("idle_after_second", int'(st), 0);
    check_record(tc);
    // reset in the middle of readout
    start_record();
    arm_and_fire(2, tc);
    k = 0;
    while (got.size() < 20 && k < 300) begin tick(); k++; end
    chk("reached_20_transfers", int'(got.size() >= 20), 1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", int'(st), 0);
    chk("mid_rst_ready", int'(rdy), 0);
    chk("mid_rst_data", int'(dout), 0);
    repeat (30) tick();
    chk("no_done_after_reset", done_cnt - d0, 0);
    start_record();
    arm_and_fire(4, tc);
    wait_done(300, 0);
    check_record(tc);
    // lane ordering with distinct lane bytes
    lane_off = 64;
    start_record();
    arm_and_fire(6, tc);
    wait_done(300, 0);
    chk("lane_n_samples", got.size(), NS);
    if (got.size() == NS) begin
      chk("lane1_order", (got[1] - got[0]) & 255, 64);
      chk("lane3_order", (got[3] - got[0]) & 255, 192);
      chk("lane_trigger_word", got[16], tc & 255);
    end
    lane_off = 0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Single-clock, parametrised trigger-capture buffer for the ADC data path. It records a ring of multi-lane ADC words with a configurable pre-trigger window, freezes the record a fixed number of words after a trigger, and streams the record out one sample at a time through a strobe handshake. The output side matches the UART transmit wrapper's ADC port: DataReady drives adcDataValid, and ReadEnable is driven by adcDataStrobe. Over the existing dual-clock accumulator it adds a programmable pre-trigger depth, generic lane count and width, arm control, and an auto-rearm mode.

## Interface
- SAMPLE_WIDTH, 8, bits per ADC sample.
- LANES, 4, samples per input word. Lane 0 is DataIn[SAMPLE_WIDTH-1:0].
- DEPTH_LOG2, 10, buffer depth is 2**DEPTH_LOG2 words.
- PRETRIG, 64, words kept before the trigger word. Legal range is 1 ≤ PRETRIG < 2**DEPTH_LOG2.
- Clock  in  1  sole clock. All logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- DataIn  in  LANES*SAMPLE_WIDTH  ADC word, sampled every cycle.
- FastTrigger  in  1  trigger. A level is accepted only in ARMED.
- Arm  in  1  single-cycle request to start a capture from IDLE.
- AutoRearm  in  1  when 1, return to ARMING after readout instead of IDLE.
- ReadEnable  in  1  consumes the sample currently on DataOut.
- DataOut  out  SAMPLE_WIDTH  current readout sample.
- DataReady  out  1  DataOut is valid and unconsumed.
- Done  out  1  one-cycle pulse after the last sample of a record is consumed.
- State  out  3  current state: IDLE=0, ARMING=1, ARMED=2, POST=3, READOUT=4.

## Operation
- Reset: State=IDLE. DataOut=0, DataReady=0, Done=0. The write pointer, fill counter and readout counters clear to 0. RAM contents are don't-care.
- IDLE: no writes occur. Arm=1 moves to ARMING on the next cycle, with the fill counter cleared.
- ARMING: DataIn is written at wptr every cycle and wptr increments mod 2**DEPTH_LOG2. FastTrigger is ignored. When PRETRIG words have been written, the block moves to ARMED.
- ARMED: writes continue. The first cycle with FastTrigger=1 defines the trigger word, which is the DataIn written that cycle. Its address tptr is latched and the block enters POST with the post counter set to 1.
- POST: writes continue until DEPTH−PRETRIG words have been written, counting the trigger word. It then enters READOUT with rptr = tptr − PRETRIG (mod depth). No further writes occur.
- READOUT:
  - 2**DEPTH_LOG2 words are read starting at rptr, in write order.
  - Within each word, samples go out lane 0 first, then lane LANES−1 last.
  - The trigger word's lane 0 is sample number PRETRIG*LANES (0-based).
- Handshake:
  - A sample is transferred on a cycle where DataReady=1 and ReadEnable=1.
  - ReadEnable while DataReady=0 is ignored.
  - DataOut is held stable while DataReady=1 and ReadEnable=0.
- After the final transfer, Done pulses the next cycle. The block goes to ARMING (AutoRearm=1) or IDLE (AutoRearm=0) in that same cycle. AutoRearm is sampled on the final transfer cycle.
- Arm outside IDLE is ignored. FastTrigger in IDLE, ARMING, POST or READOUT is ignored and is not queued.
- Reset in any state, including mid-readout, aborts immediately to reset values. A partial record is discarded.
- Pointer and counter arithmetic is unsigned, DEPTH_LOG2 bits, and wraps modulo depth. Counters are DEPTH_LOG2+1 bits wide so a full depth can be counted.

## Timing
- The RAM has a 1-cycle registered read. There is no combinational path from input to output.
- First sample: DataReady rises 2 cycles after entering READOUT (one cycle to present the address, one for read data).
- Within a word, the next sample appears the cycle after a transfer and DataReady stays 1. This permits back-to-back transfers at 1 sample per clock.
- Word boundary: after the lane LANES−1 transfer, DataReady is 0 for exactly 2 cycles, then the next word's lane 0 is presented.
- Trigger to READOUT entry: DEPTH−PRETRIG cycles after the trigger cycle.
- Done is asserted for exactly one cycle. In that cycle DataReady=0.

## Test plan
All scenarios use LANES=4, SAMPLE_WIDTH=8, DEPTH_LOG2=4 (16 words) and PRETRIG=4. Every byte of DataIn equals the write-cycle count.
- Basic capture: pulse Arm, hold a 1-cycle FastTrigger 10 cycles after ARMED, with ReadEnable held at 1.
  - Expect exactly 64 samples, in 4-sample groups of equal value.
  - Group 4 equals the trigger-cycle count.
  - Groups increase by 1 per group.
  - Done pulses once; State returns to 0.
- Early trigger: FastTrigger=1 during ARMING cycles 1–3, then low.
  - Expect State to remain 1, then 2.
  - No capture happens until a new trigger arrives in ARMED.
- Ring wrap: wait 37 cycles in ARMED, then trigger.
  - Readout must wrap through address 15 to 0 and remain contiguous (rptr = tptr−4 mod 16).
- Backpressure: toggle ReadEnable randomly.
  - DataOut must stay stable while held, and no sample may be lost or duplicated (64 transfers).
  - Check the 2-cycle DataReady gap at each word boundary.
- AutoRearm=1: after Done, expect State=1 the same cycle, then a second trigger produces a second valid 64-sample record.
- Reset mid-readout: assert Reset after transfer 20.
  - Next cycle: State=0, DataReady=0, DataOut=0, and Done is never pulsed.
  - A subsequent Arm/trigger must give a clean record.
